// File: rtl/nx_ram_1r1w_fifo_ctrl.sv
// Streaming FIFO controller driving a 1r1w RAM (input and output flops, 2-cycle read latency).
// The RAM's write-commit delay and read latency are hidden behind a 3-entry output skid buffer.
module nx_ram_1r1w_fifo_ctrl #(
    parameter int WIDTH = 71,
    parameter int DEPTH = 2048,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW+1:0]    count,
    output logic             web,
    output logic [AW-1:0]    wa,
    output logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] bwe,
    output logic             reb,
    output logic [AW-1:0]    ra,
    input  logic [WIDTH-1:0] dout
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    function automatic logic [1:0] slot_next(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      ram_cnt, rdy_cnt;
    logic [1:0]       commit_pipe;
    logic [1:0]       rd_pipe;
    logic [1:0]       out_cnt, out_head, out_tail;
    logic [WIDTH-1:0] out_mem [3];

    logic       push, pop, issue, committed;
    logic [1:0] inflight;
    logic [2:0] credit_used;

    assign wr_ready    = (ram_cnt < FULL_CNT);
    assign push        = wr_valid & wr_ready;
    assign rd_valid    = (out_cnt != 2'd0);
    assign pop         = rd_valid & rd_ready;
    assign rd_data     = out_mem[out_head];

    // A word whose stage-2 strobe is set this cycle is already in the array, so it
    // counts as committed now; rdy_cnt absorbs it at the end of the cycle.
    assign committed   = (rdy_cnt != '0) | commit_pipe[1];
    assign inflight    = {1'b0, rd_pipe[0]} + {1'b0, rd_pipe[1]};
    assign credit_used = {1'b0, out_cnt} + {1'b0, inflight};
    // A pop in the same cycle frees a buffer slot, which keeps reads issuing
    // back-to-back while the consumer drains one word per cycle.
    assign issue       = committed & (credit_used < (3'd3 + {2'b0, pop}));

    assign web   = ~push;
    assign wa    = wptr;
    assign din   = wr_data;
    assign bwe   = '1;
    assign reb   = ~issue;
    assign ra    = rptr;
    assign count = {1'b0, ram_cnt} + (AW+2)'(inflight) + (AW+2)'(out_cnt);

    // NOTE: every register here uses <= so all updates see the pre-edge values;
    // blocking assignments would make later lines read already-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            ram_cnt     <= '0;
            rdy_cnt     <= '0;
            commit_pipe <= '0;
            rd_pipe     <= '0;
            out_cnt     <= '0;
            out_head    <= '0;
            out_tail    <= '0;
        end else begin
            if (push)  wptr <= wptr + AW'(1);
            if (issue) rptr <= rptr + AW'(1);

            unique case ({push, issue})
                2'b10:   ram_cnt <= ram_cnt + (AW+1)'(1);
                2'b01:   ram_cnt <= ram_cnt - (AW+1)'(1);
                default: ;
            endcase

            commit_pipe <= {commit_pipe[0], push};
            unique case ({commit_pipe[1], issue})
                2'b10:   rdy_cnt <= rdy_cnt + (AW+1)'(1);
                2'b01:   rdy_cnt <= rdy_cnt - (AW+1)'(1);
                default: ;
            endcase

            // Stage 2 marks the cycle in which dout holds the word for that read.
            rd_pipe <= {rd_pipe[0], issue};
            if (rd_pipe[1]) out_tail <= slot_next(out_tail);
            if (pop)        out_head <= slot_next(out_head);
            unique case ({rd_pipe[1], pop})
                2'b10:   out_cnt <= out_cnt + 2'd1;
                2'b01:   out_cnt <= out_cnt - 2'd1;
                default: ;
            endcase
        end
    end

    // NOTE: the buffer storage has no reset; out_cnt alone decides which slots
    // are meaningful, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (rd_pipe[1]) out_mem[out_tail] <= dout;
    end

endmodule

// File: tb/tb_nx_ram_1r1w_fifo_ctrl.sv
// Self-checking bench: behavioural RAM plus a queue-based reference model of the FIFO,
// compared against the controller on every falling clock edge.
module tb_nx_ram_1r1w_fifo_ctrl;

    localparam int WIDTH = 71;
    localparam int DEPTH = 2048;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic [AW+1:0]    count;
    logic             web;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] bwe;
    logic             reb;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nx_ram_1r1w_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count),
        .web(web), .wa(wa), .din(din), .bwe(bwe),
        .reb(reb), .ra(ra), .dout(dout)
    );

    // Behavioural RAM: input flops, array written one edge later, output flop.
    logic [WIDTH-1:0] ram_arr [DEPTH];
    logic             web_q = 1'b1, reb_q = 1'b1;
    logic [AW-1:0]    wa_q, ra_q;
    logic [WIDTH-1:0] din_q, bwe_q, dout_q;
    assign dout = dout_q;

    always @(posedge clk) begin
        if (!web_q) ram_arr[wa_q] <= (ram_arr[wa_q] & ~bwe_q) | (din_q & bwe_q);
        if (!reb_q) dout_q <= ram_arr[ra_q];
        web_q <= web;
        wa_q  <= wa;
        din_q <= din;
        bwe_q <= bwe;
        reb_q <= reb;
        ra_q  <= ra;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words waiting in RAM (with push cycle), reads in flight
    // (with issue cycle), and the words visible to the consumer.
    typedef struct {
        logic [WIDTH-1:0] d;
        int               t;
    } ent_t;

    ent_t             q_ram[$];
    ent_t             q_fly[$];
    logic [WIDTH-1:0] q_out[$];
    int               m_cyc, m_wa, m_ra, n_push, n_pop;
    bit               e_push, e_pop, e_issue;
    ent_t             e_tmp;

    always @(negedge clk) begin
        if (!rst_n) begin
            q_ram.delete();
            q_fly.delete();
            q_out.delete();
            m_cyc  = 0;
            m_wa   = 0;
            m_ra   = 0;
            n_push = 0;
            n_pop  = 0;
        end else begin
            e_push  = wr_valid && (q_ram.size() < DEPTH);
            e_pop   = rd_ready && (q_out.size() != 0);
            e_issue = (q_ram.size() != 0) && (m_cyc >= q_ram[0].t + 2) &&
                      (q_out.size() + q_fly.size() - int'(e_pop) < 3);

            check("wr_ready", wr_ready, q_ram.size() < DEPTH);
            check("rd_valid", rd_valid, q_out.size() != 0);
            if (q_out.size() != 0) check("rd_data", rd_data, q_out[0]);
            check("count", count, q_ram.size() + q_fly.size() + q_out.size());
            check("count_vs_handshakes", count, n_push - n_pop);
            check("web", web, !e_push);
            if (e_push) check("wa", wa, m_wa);
            check("din", din, wr_data);
            check("bwe", bwe, {WIDTH{1'b1}});
            check("reb", reb, !e_issue);
            if (e_issue) check("ra", ra, m_ra);

            if (e_pop) begin
                void'(q_out.pop_front());
                n_pop++;
            end
            if (q_fly.size() != 0 && q_fly[0].t + 2 == m_cyc) begin
                e_tmp = q_fly.pop_front();
                q_out.push_back(e_tmp.d);
            end
            if (e_issue) begin
                e_tmp = q_ram.pop_front();
                e_tmp.t = m_cyc;
                q_fly.push_back(e_tmp);
                m_ra = (m_ra + 1) % DEPTH;
            end
            if (e_push) begin
                e_tmp.d = wr_data;
                e_tmp.t = m_cyc;
                q_ram.push_back(e_tmp);
                m_wa = (m_wa + 1) % DEPTH;
                n_push++;
            end
            m_cyc++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int lat, found, n_issue, i_first, i_last, n_pops, p_first, p_last, accepted, pw, pr;
    logic [WIDTH-1:0] first_data;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_web", web, 1);
        check("rst_reb", reb, 1);
        check("rst_wa", wa, 0);
        check("rst_ra", ra, 0);
        rst_n = 1'b1;
        next_cycle();

        // Single word: push at cycle 0, rd_valid first in cycle 5
        wr_valid = 1'b1;
        wr_data  = 71'h1;
        rd_ready = 1'b1;
        next_cycle();
        wr_valid = 1'b0;
        lat   = 1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (rd_valid) found = 1;
            else begin
                lat++;
                next_cycle();
            end
        end
        check("single_found", found, 1);
        check("single_latency", lat, 5);
        check("single_data", rd_data, 71'h1);
        next_cycle();
        @(negedge clk);
        check("single_count_after_pop", count, 0);
        next_cycle();

        // Streaming: 100 back-to-back pushes with the consumer always ready
        n_issue = 0; i_first = -1; i_last = -1;
        n_pops  = 0; p_first = -1; p_last = -1;
        for (int c = 0; c < 115; c++) begin
            wr_valid = (c < 100);
            wr_data  = 71'h1000 + 71'(c);
            @(negedge clk);
            if (!reb) begin
                if (i_first < 0) i_first = c;
                i_last = c;
                n_issue++;
            end
            if (rd_valid && rd_ready) begin
                if (p_first < 0) p_first = c;
                p_last = c;
                n_pops++;
            end
            next_cycle();
        end
        check("stream_issues", n_issue, 100);
        check("stream_first_issue", i_first, 2);
        check("stream_issue_span", i_last - i_first, 99);
        check("stream_pops", n_pops, 100);
        check("stream_first_pop", p_first, 5);
        check("stream_pop_span", p_last - p_first, 99);

        // Fill with the consumer stalled
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        accepted = 0;
        for (int c = 0; c < DEPTH + 50; c++) begin
            wr_data = 71'h7_0000 + 71'(c);
            @(negedge clk);
            if (!wr_ready) break;
            accepted++;
            next_cycle();
        end
        check("fill_accepted", accepted, DEPTH + 3);
        check("fill_count", count, DEPTH + 3);
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("full_web_high", web, 1);
            next_cycle();
        end

        // Drain across the pointer wrap while refilling
        rd_ready = 1'b1;
        @(negedge clk);
        check("drain_first_issue", reb, 0);
        check("drain_ready_still_low", wr_ready, 0);
        next_cycle();
        @(negedge clk);
        check("drain_ready_rises", wr_ready, 1);
        next_cycle();
        for (int c = 0; c < 60; c++) begin
            wr_data = 71'h9_0000 + 71'(c);
            next_cycle();
        end
        wr_valid = 1'b0;
        repeat (DEPTH + 20) next_cycle();
        @(negedge clk);
        check("drain_empty_count", count, 0);
        check("drain_empty_valid", rd_valid, 0);
        next_cycle();

        // Random valid/ready on both sides
        pw = 5;
        pr = 5;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) begin
                pw = $urandom_range(1, 9);
                pr = $urandom_range(1, 9);
            end
            wr_valid = ($urandom_range(0, 9) < pw);
            rd_ready = ($urandom_range(0, 9) < pr);
            wr_data  = WIDTH'({$urandom(), $urandom(), $urandom()});
            next_cycle();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        repeat (DEPTH + 20) next_cycle();
        @(negedge clk);
        check("random_drained", count, 0);
        next_cycle();

        // Reset mid-stream with words queued and two reads in flight
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wr_data = 71'h500 + 71'(i);
            next_cycle();
        end
        wr_valid = 1'b0;
        repeat (8) next_cycle();
        rd_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        check("pre_reset_count", count, 14);
        next_cycle();
        rd_ready = 1'b0;
        check("pre_reset_count_inflight", count, 13);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_wr_ready", wr_ready, 1);
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_web", web, 1);
        check("midrst_reb", reb, 1);
        check("midrst_wa", wa, 0);
        check("midrst_ra", ra, 0);
        next_cycle();
        next_cycle();
        rst_n    = 1'b1;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 71'hA00 + 71'(i);
            next_cycle();
        end
        wr_valid   = 1'b0;
        n_pops     = 0;
        first_data = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                if (n_pops == 0) first_data = rd_data;
                n_pops++;
            end
            next_cycle();
        end
        check("post_reset_first_data", first_data, 71'hA00);
        check("post_reset_pops", n_pops, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
